// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation codes and datapath select encodings.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_WB,
        S_LUI, S_AUIPC
    } state_e;

    typedef enum logic [1:0] {
        ACLS_ADD, ACLS_R, ACLS_I, ACLS_BR
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Comparisons leave zero set when "not less", so BLT-style branches take on ~zero.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        case (funct3)
            3'b000, 3'b101, 3'b111: return zero;
            3'b001, 3'b100, 3'b110: return ~zero;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU usage class plus funct3/funct7b5 onto the ALU op code.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_class_e  alu_cls,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [3:0]  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_cls)
            ACLS_R:  alu_ctrl = {funct7b5, funct3};
            // Only shifts use bit 30 as an opcode bit for immediates; ADDI stays ADD.
            ACLS_I:  alu_ctrl = {funct7b5 & (funct3 == 3'b101), funct3};
            ACLS_BR: begin
                case (funct3[2:1])
                    2'b00:   alu_ctrl = ALU_SUB;
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences one instruction at a time and drives
// all datapath selects and write enables from the current state.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic        illegal
);

    state_e     state_q, state_d;
    alu_class_e alu_cls;
    logic       ready;

    assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_cls    = ACLS_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_cls   = ACLS_R;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_cls   = ACLS_I;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                result_src = RES_ALUOUT;
                alu_cls    = ACLS_BR;
                pc_write   = branch_taken(funct3, zero);
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_I;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = S_JALR_WB;
            end
            S_JALR_WB: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset quiesces the datapath in the same cycle so an aborted instruction writes nothing.
        if (reset) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = RES_ALUOUT;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            imm_src    = IMM_I;
            alu_cls    = ACLS_ADD;
            illegal    = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_cls  (alu_cls),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_ctrl (alu_ctrl)
    );

endmodule
